// File: rtl/btime_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : btime_loader_pkg
//  Purpose  : Shared types and constants for the Burger Time ROM loader.
//             Holds the download region map (bases and last addresses within
//             the 64 KiB image), the region and FSM state enums.
//  Revision : 1.0  initial release
// ============================================================================
package btime_loader_pkg;

  // Region bases within the 64 KiB ROM image (bit 16 and above must be zero)
  localparam logic [15:0] c_CPU_BASE = 16'h0000;
  localparam logic [15:0] c_CPU_LAST = 16'h7FFF;
  localparam logic [15:0] c_SND_BASE = 16'h8000;
  localparam logic [15:0] c_SND_LAST = 16'h8FFF;
  localparam logic [15:0] c_FG_BASE  = 16'h9000;
  localparam logic [15:0] c_FG_LAST  = 16'hEFFF;
  localparam logic [15:0] c_BG_BASE  = 16'hF000;
  localparam logic [15:0] c_BG_LAST  = 16'hF7FF;
  localparam logic [15:0] c_MAP_BASE = 16'hF800;

  // Saturation value for the accepted-byte counter
  localparam logic [16:0] c_COUNT_MAX = 17'h1FFFF;

  typedef enum logic [2:0] {
    REG_CPU  = 3'd0,
    REG_SND  = 3'd1,
    REG_FG   = 3'd2,
    REG_BG   = 3'd3,
    REG_MAP  = 3'd4,
    REG_NONE = 3'd5
  } region_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    HOLD  = 3'd3,
    RUN   = 3'd4
  } state_e;

endpackage : btime_loader_pkg
`default_nettype wire

// File: rtl/btime_region_decode.sv
`default_nettype none
// ============================================================================
//  Module   : btime_region_decode
//  Purpose  : Combinational map of a flat 25-bit download address to a ROM
//             region and a 16-bit region-relative offset. Addresses at or
//             above 0x10000 decode to REG_NONE with a zero offset.
//  Revision : 1.0  initial release
// ============================================================================
module btime_region_decode
  import btime_loader_pkg::*;
(
  input  logic [24:0] i_addr,
  output region_e     o_region,
  output logic [15:0] o_offset
);

  logic [15:0] w_lo;
  assign w_lo = i_addr[15:0];

  // Cascade of upper-bound compares; the regions are contiguous and ascending
  always_comb begin
    o_region = REG_NONE;
    o_offset = 16'h0000;
    if (i_addr[24:16] == 9'd0) begin
      if (w_lo <= c_CPU_LAST) begin
        o_region = REG_CPU;
        o_offset = w_lo - c_CPU_BASE;
      end else if (w_lo <= c_SND_LAST) begin
        o_region = REG_SND;
        o_offset = w_lo - c_SND_BASE;
      end else if (w_lo <= c_FG_LAST) begin
        o_region = REG_FG;
        o_offset = w_lo - c_FG_BASE;
      end else if (w_lo <= c_BG_LAST) begin
        o_region = REG_BG;
        o_offset = w_lo - c_BG_BASE;
      end else begin
        o_region = REG_MAP;
        o_offset = w_lo - c_MAP_BASE;
      end
    end
  end

endmodule : btime_region_decode
`default_nettype wire

// File: rtl/btime_rom_loader.sv
`default_nettype none
// ============================================================================
//  Module   : btime_rom_loader
//  Purpose  : Download sequencer between the hps_io ioctl byte stream and the
//             Burger Time ROMs. Routes each byte to its region with a
//             registered write strobe, validates the image length, and holds
//             the core in reset during load and for HOLD_CYCLES afterwards
//             (also re-applied while ext_reset is high).
//  Options  : BTIME_LOADER_CKSUM_EN - when defined, checksum reports the 8-bit
//             wrapping sum of accepted in-range bytes; otherwise it is 0.
//  Revision : 1.0  initial release
// ============================================================================
module btime_rom_loader
  import btime_loader_pkg::*;
#(
  parameter int          HOLD_CYCLES  = 16,
  parameter logic [16:0] EXPECTED_LEN = 17'h10000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        ext_reset,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        cpu_we,
  output logic        snd_we,
  output logic        fg_we,
  output logic        bg_we,
  output logic        map_we,
  output logic        core_reset,
  output logic        load_done,
  output logic        load_err,
  output logic [16:0] byte_count,
  output logic [7:0]  checksum
);

  localparam int c_HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [c_HOLD_W-1:0] c_HOLD_LOAD = c_HOLD_W'(HOLD_CYCLES - 1);

  state_e              r_state;
  logic                r_dl_q;
  logic [c_HOLD_W-1:0] r_hold_cnt;
  logic                r_oor;
  logic [16:0]         r_byte_count;
  logic                r_load_done;
  logic                r_load_err;
  logic [15:0]         r_wr_addr;
  logic [7:0]          r_wr_data;
  logic                r_cpu_we, r_snd_we, r_fg_we, r_bg_we, r_map_we;

  logic                w_dl_rise;
  logic                w_dl_fall;
  logic                w_accept;
  region_e             w_region;
  logic [15:0]         w_offset;

  btime_region_decode u_decode (
    .i_addr   (ioctl_addr),
    .o_region (w_region),
    .o_offset (w_offset)
  );

  assign w_dl_rise = ioctl_download & ~r_dl_q;
  assign w_dl_fall = ~ioctl_download & r_dl_q;
  // A byte landing on the same cycle as the download fall is still in LOAD
  assign w_accept  = (r_state == LOAD) & ioctl_wr;

  // Sequencer: a download rise wins over everything, including ext_reset
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_dl_q     <= 1'b0;
      r_hold_cnt <= '0;
    end else begin
      r_dl_q <= ioctl_download;
      if (w_dl_rise) begin
        r_state <= LOAD;
      end else begin
        case (r_state)
          IDLE: r_state <= IDLE;
          LOAD: if (w_dl_fall) r_state <= CHECK;
          CHECK: begin
            r_state    <= HOLD;
            r_hold_cnt <= c_HOLD_LOAD;
          end
          HOLD: begin
            if (ext_reset) begin
              r_hold_cnt <= c_HOLD_LOAD;
            end else if (r_hold_cnt == '0) begin
              r_state <= RUN;
            end else begin
              r_hold_cnt <= r_hold_cnt - 1'b1;
            end
          end
          RUN: begin
            if (ext_reset) begin
              r_state    <= HOLD;
              r_hold_cnt <= c_HOLD_LOAD;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  // Load bookkeeping: cleared on LOAD entry, verdict latched in CHECK
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_byte_count <= '0;
      r_oor        <= 1'b0;
      r_load_done  <= 1'b0;
      r_load_err   <= 1'b0;
    end else if (w_dl_rise) begin
      r_byte_count <= '0;
      r_oor        <= 1'b0;
      r_load_done  <= 1'b0;
      r_load_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        if (r_byte_count != c_COUNT_MAX) r_byte_count <= r_byte_count + 17'd1;
        if (w_region == REG_NONE) r_oor <= 1'b1;
      end
      if (r_state == CHECK) begin
        r_load_err  <= r_oor | (r_byte_count != EXPECTED_LEN);
        r_load_done <= 1'b1;
      end
    end
  end

  // Registered write port: one strobe per accepted in-range byte
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_cpu_we  <= 1'b0;
      r_snd_we  <= 1'b0;
      r_fg_we   <= 1'b0;
      r_bg_we   <= 1'b0;
      r_map_we  <= 1'b0;
    end else begin
      r_cpu_we <= 1'b0;
      r_snd_we <= 1'b0;
      r_fg_we  <= 1'b0;
      r_bg_we  <= 1'b0;
      r_map_we <= 1'b0;
      if (w_accept && (w_region != REG_NONE)) begin
        r_wr_addr <= w_offset;
        r_wr_data <= ioctl_dout;
        case (w_region)
          REG_CPU: r_cpu_we <= 1'b1;
          REG_SND: r_snd_we <= 1'b1;
          REG_FG:  r_fg_we  <= 1'b1;
          REG_BG:  r_bg_we  <= 1'b1;
          REG_MAP: r_map_we <= 1'b1;
          default: r_cpu_we <= 1'b0;
        endcase
      end
    end
  end

`ifdef BTIME_LOADER_CKSUM_EN
  logic [7:0] r_checksum;
  logic       w_strobe;
  assign w_strobe = r_cpu_we | r_snd_we | r_fg_we | r_bg_we | r_map_we;

  // Running sum of the byte currently presented on the write port
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_checksum <= 8'h00;
    end else if (w_dl_rise) begin
      r_checksum <= 8'h00;
    end else if (w_strobe) begin
      r_checksum <= r_checksum + r_wr_data;
    end
  end

  assign checksum = r_checksum;
`else
  assign checksum = 8'h00;
`endif

  assign core_reset = (r_state != RUN);
  assign load_done  = r_load_done;
  assign load_err   = r_load_err;
  assign byte_count = r_byte_count;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign cpu_we     = r_cpu_we;
  assign snd_we     = r_snd_we;
  assign fg_we      = r_fg_we;
  assign bg_we      = r_bg_we;
  assign map_we     = r_map_we;

endmodule : btime_rom_loader
`default_nettype wire
